hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter TAM_DIREC_REG, default 5, register address width.
REQ-002 Parameter TAM_STALL_CNT, default 32, stall-statistics counter width.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_rs_if_id, i_rt_if_id  input  TAM_DIREC_REG  source registers of the instruction in ID.
REQ-006 i_use_rs, i_use_rt  input  1  ID instruction actually reads rs / rt.
REQ-007 i_rd_id_ex, i_rd_ex_mem  input  TAM_DIREC_REG  destination registers in EX and MEM.
REQ-008 i_mem_rd_id_ex, i_mem_rd_ex_mem  input  1  instruction in EX / MEM is a load.
REQ-009 i_reg_wr_id_ex, i_reg_wr_ex_mem  input  1  instruction in EX / MEM writes the register file.
REQ-010 i_branch_taken  input  1  branch/jump resolved taken in ID this cycle.
REQ-011 i_halt_id  input  1  HALT instruction present in ID.
REQ-012 o_pc_write  output  1  PC update enable.
REQ-013 o_if_id_write  output  1  IF/ID register load enable.
REQ-014 o_id_ex_bubble  output  1  force NOP control into ID/EX.
REQ-015 o_if_id_flush  output  1  clear IF/ID (squash fetched instruction).
REQ-016 o_halted  output  1  pipeline drained after HALT.
REQ-017 o_stall_count  output  TAM_STALL_CNT  total stall cycles since reset.

Function
REQ-018 Hazard match (per operand): use flag set, source != 0, source equals the load's destination, and the load's reg_wr asserted.
REQ-019 FSM states: RUN, STALL, DRAIN, HALTED.
REQ-020 RUN, load in EX matching an ID operand: load counter with 1, go STALL, stall outputs asserted in the detecting cycle (2 total stall cycles).
REQ-021 RUN, no EX match, load in MEM matching an ID operand: stall this cycle only, stay RUN.
REQ-022 Stall outputs: o_pc_write=0, o_if_id_write=0, o_id_ex_bubble=1, o_if_id_flush=0.
REQ-023 STALL: stall outputs asserted; counter decrements; counter 0 -> RUN next cycle.
REQ-024 RUN, no hazard, i_branch_taken=1: o_if_id_flush=1 in the same cycle (combinational), PC and IF/ID writes enabled.
REQ-025 i_branch_taken is ignored during any stall cycle (operands not valid).
REQ-026 RUN, i_halt_id=1: halt has priority over hazard and branch; o_pc_write=0, o_if_id_write=0, load counter with 3, go DRAIN.
REQ-027 DRAIN: o_pc_write=0, o_if_id_write=0, o_id_ex_bubble=1; counter decrements; counter 0 -> HALTED.
REQ-028 HALTED: as DRAIN, o_halted=1; exit only by reset.
REQ-029 RUN with no event: o_pc_write=1, o_if_id_write=1, o_id_ex_bubble=0, o_if_id_flush=0.
REQ-030 o_stall_count increments by 1 per cycle where o_id_ex_bubble=1 in RUN or STALL; saturates at all-ones, no wrap.
REQ-031 Register 0 never produces a hazard.

Reset
REQ-032 On i_rst=1 at a clock edge: state RUN, counter 0, o_stall_count 0, o_halted 0; valid from any state, including mid-STALL or DRAIN.
REQ-033 While i_rst=1, outputs take their RUN-with-no-event values.

Structure
REQ-034 The shared pipeline package holds the FSM state encoding, the drain depth (3) and the load-use stall depths (2 and 1).
REQ-035 The block is a single module with no sub-modules; the per-operand match is a local function.

Verification
REQ-036 Load r5 in EX, ID uses rs=5 -> 2 consecutive cycles with pc_write=0 and bubble=1, then RUN; stall_count=2.
REQ-037 Load r5 in MEM only, ID uses rt=5 -> exactly 1 stall cycle.
REQ-038 Load r0 in EX, ID uses rs=0 -> no stall.
REQ-039 i_branch_taken=1 in the first STALL cycle -> flush stays 0; the same branch taken in RUN -> flush=1 for one cycle.
REQ-040 i_halt_id=1 -> 3 DRAIN cycles, then o_halted=1, held for 10 cycles; i_rst -> RUN and o_halted=0.
REQ-041 i_rst asserted in STALL -> next cycle pc_write=1, stall_count=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared pipeline definitions: hazard FSM encoding and pipeline drain/stall depths.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } hz_state_e;

    localparam int DRAIN_DEPTH  = 3;
    localparam int LU_EX_STALL  = 2;  // load in EX: detect cycle + one more
    localparam int LU_MEM_STALL = 1;  // load in MEM: detect cycle only
    localparam int CNT_W        = 2;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection, branch flush and HALT drain control for the ID stage.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int TAM_DIREC_REG = 5,
    parameter int TAM_STALL_CNT = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [TAM_DIREC_REG-1:0] i_rs_if_id,
    input  logic [TAM_DIREC_REG-1:0] i_rt_if_id,
    input  logic                     i_use_rs,
    input  logic                     i_use_rt,
    input  logic [TAM_DIREC_REG-1:0] i_rd_id_ex,
    input  logic [TAM_DIREC_REG-1:0] i_rd_ex_mem,
    input  logic                     i_mem_rd_id_ex,
    input  logic                     i_mem_rd_ex_mem,
    input  logic                     i_reg_wr_id_ex,
    input  logic                     i_reg_wr_ex_mem,
    input  logic                     i_branch_taken,
    input  logic                     i_halt_id,
    output logic                     o_pc_write,
    output logic                     o_if_id_write,
    output logic                     o_id_ex_bubble,
    output logic                     o_if_id_flush,
    output logic                     o_halted,
    output logic [TAM_STALL_CNT-1:0] o_stall_count
);

    hz_state_e                state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [TAM_STALL_CNT-1:0] stall_cnt_q;
    logic                     haz_ex, haz_mem, cnt_en;

    // Register 0 is hardwired to zero, so it can never carry a load-use dependency.
    function automatic logic op_match(input logic use_f,
                                      input logic [TAM_DIREC_REG-1:0] src,
                                      input logic [TAM_DIREC_REG-1:0] dst,
                                      input logic wr);
        return use_f && (src != '0) && (src == dst) && wr;
    endfunction

    assign haz_ex  = i_mem_rd_id_ex &&
                     (op_match(i_use_rs, i_rs_if_id, i_rd_id_ex, i_reg_wr_id_ex) ||
                      op_match(i_use_rt, i_rt_if_id, i_rd_id_ex, i_reg_wr_id_ex));
    assign haz_mem = i_mem_rd_ex_mem &&
                     (op_match(i_use_rs, i_rs_if_id, i_rd_ex_mem, i_reg_wr_ex_mem) ||
                      op_match(i_use_rt, i_rt_if_id, i_rd_ex_mem, i_reg_wr_ex_mem));

    always_comb begin
        o_pc_write     = 1'b1;
        o_if_id_write  = 1'b1;
        o_id_ex_bubble = 1'b0;
        o_if_id_flush  = 1'b0;
        state_d        = state_q;
        cnt_d          = cnt_q;
        if (!i_rst) begin
            case (state_q)
                ST_RUN: begin
                    if (i_halt_id) begin
                        o_pc_write    = 1'b0;
                        o_if_id_write = 1'b0;
                        cnt_d         = CNT_W'(DRAIN_DEPTH);
                        state_d       = ST_DRAIN;
                    end else if (haz_ex || haz_mem) begin
                        o_pc_write     = 1'b0;
                        o_if_id_write  = 1'b0;
                        o_id_ex_bubble = 1'b1;
                        if (haz_ex) begin
                            cnt_d   = CNT_W'(LU_EX_STALL - 1);
                            state_d = ST_STALL;
                        end
                    end else begin
                        o_if_id_flush = i_branch_taken;
                    end
                end
                ST_STALL: begin
                    o_pc_write     = 1'b0;
                    o_if_id_write  = 1'b0;
                    o_id_ex_bubble = 1'b1;
                    cnt_d          = cnt_q - 1'b1;
                    if (cnt_d == '0) state_d = ST_RUN;
                end
                ST_DRAIN: begin
                    o_pc_write     = 1'b0;
                    o_if_id_write  = 1'b0;
                    o_id_ex_bubble = 1'b1;
                    cnt_d          = cnt_q - 1'b1;
                    if (cnt_d == '0) state_d = ST_HALTED;
                end
                ST_HALTED: begin
                    o_pc_write     = 1'b0;
                    o_if_id_write  = 1'b0;
                    o_id_ex_bubble = 1'b1;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Drain bubbles are not load-use stalls and stay out of the statistic.
    assign cnt_en = o_id_ex_bubble && ((state_q == ST_RUN) || (state_q == ST_STALL));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cnt_en && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign o_halted      = (state_q == ST_HALTED) && !i_rst;
    assign o_stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: expected control per cycle queued, compared mid-cycle.
module tb_hazard_unit;

    localparam int AW = 5;
    localparam int SW = 3;

    typedef struct packed {
        logic          pc;
        logic          ifid;
        logic          bub;
        logic          flush;
        logic          halted;
        logic [SW-1:0] sc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs, rt, rd_ex, rd_mem;
    logic          use_rs, use_rt, ld_ex, ld_mem, wr_ex, wr_mem, br, halt;
    logic          pc_w, ifid_w, bub, flush, halted;
    logic [SW-1:0] sc;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    hazard_unit #(.TAM_DIREC_REG(AW), .TAM_STALL_CNT(SW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rs_if_id(rs), .i_rt_if_id(rt), .i_use_rs(use_rs), .i_use_rt(use_rt),
        .i_rd_id_ex(rd_ex), .i_rd_ex_mem(rd_mem),
        .i_mem_rd_id_ex(ld_ex), .i_mem_rd_ex_mem(ld_mem),
        .i_reg_wr_id_ex(wr_ex), .i_reg_wr_ex_mem(wr_mem),
        .i_branch_taken(br), .i_halt_id(halt),
        .o_pc_write(pc_w), .o_if_id_write(ifid_w), .o_id_ex_bubble(bub),
        .o_if_id_flush(flush), .o_halted(halted), .o_stall_count(sc)
    );

    task automatic idle();
        rs = '0; rt = '0; rd_ex = '0; rd_mem = '0;
        use_rs = 0; use_rt = 0; ld_ex = 0; ld_mem = 0; wr_ex = 0; wr_mem = 0;
        br = 0; halt = 0;
    endtask

    task automatic load_ex(input logic [AW-1:0] r, input logic wr);
        rd_ex = r; ld_ex = 1'b1; wr_ex = wr;
    endtask

    task automatic load_mem(input logic [AW-1:0] r);
        rd_mem = r; ld_mem = 1'b1; wr_mem = 1'b1;
    endtask

    // Queue expectation for the current cycle, compare at negedge, advance past next posedge.
    task automatic step(input string tag, input logic p, input logic f_w, input logic b,
                        input logic fl, input logic h, input int cnt);
        exp_t e, got;
        e = '{pc: p, ifid: f_w, bub: b, flush: fl, halted: h, sc: SW'(cnt)};
        exp_q.push_back(e);
        @(negedge clk);
        got = '{pc: pc_w, ifid: ifid_w, bub: bub, flush: flush, halted: halted, sc: sc};
        e = exp_q.pop_front();
        vectors++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s: got pc=%b ifid=%b bub=%b flush=%b halted=%b sc=%0d exp pc=%b ifid=%b bub=%b flush=%b halted=%b sc=%0d",
                   tag, got.pc, got.ifid, got.bub, got.flush, got.halted, got.sc,
                   e.pc, e.ifid, e.bub, e.flush, e.halted, e.sc);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        step("reset_outputs", 1, 1, 0, 0, 0, 0);
        rst = 1'b0;
        step("run_idle", 1, 1, 0, 0, 0, 0);

        // Load r5 in EX, ID reads rs=5: two stall cycles; branch during stall ignored.
        rs = 5; use_rs = 1; load_ex(5, 1);
        step("ex_stall_1", 0, 0, 1, 0, 0, 0);
        idle(); br = 1;
        step("ex_stall_2_br_ignored", 0, 0, 1, 0, 0, 1);
        step("branch_flush_run", 1, 1, 0, 1, 0, 2);
        idle();
        step("after_ex_stall", 1, 1, 0, 0, 0, 2);

        // Load r5 in MEM only, ID reads rt=5: single stall cycle.
        rt = 5; use_rt = 1; load_mem(5);
        step("mem_stall", 0, 0, 1, 0, 0, 2);
        idle();
        step("after_mem_stall", 1, 1, 0, 0, 0, 3);

        // No-hazard corners: r0, non-writing load, operand not used.
        rs = 0; use_rs = 1; load_ex(0, 1);
        step("r0_no_stall", 1, 1, 0, 0, 0, 3);
        idle(); rs = 5; use_rs = 1; load_ex(5, 0);
        step("no_regwr_no_stall", 1, 1, 0, 0, 0, 3);
        idle(); rt = 7; use_rt = 0; load_mem(7);
        step("unused_rt_no_stall", 1, 1, 0, 0, 0, 3);

        // HALT beats a simultaneous hazard and branch.
        idle(); halt = 1; br = 1; rs = 5; use_rs = 1; load_ex(5, 1);
        step("halt_detect", 0, 0, 0, 0, 0, 3);
        idle();
        for (int i = 0; i < 3; i++) step($sformatf("drain_%0d", i), 0, 0, 1, 0, 0, 3);
        for (int i = 0; i < 10; i++) step($sformatf("halted_%0d", i), 0, 0, 1, 0, 1, 3);
        rst = 1'b1;
        step("reset_from_halted", 1, 1, 0, 0, 0, 3);
        rst = 1'b0;
        step("run_after_halt_reset", 1, 1, 0, 0, 0, 0);

        // Reset in the middle of a STALL.
        rs = 9; use_rs = 1; load_ex(9, 1);
        step("stall_before_reset", 0, 0, 1, 0, 0, 0);
        idle(); rst = 1'b1;
        step("reset_in_stall", 1, 1, 0, 0, 0, 1);
        rst = 1'b0;
        step("run_after_stall_reset", 1, 1, 0, 0, 0, 0);

        // Stall counter saturates at all-ones.
        rt = 3; use_rt = 1; load_mem(3);
        for (int i = 0; i < 9; i++)
            step($sformatf("sat_%0d", i), 0, 0, 1, 0, 0, (i > 7) ? 7 : i);
        idle();
        step("sat_hold", 1, 1, 0, 0, 0, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion exp completion");
        $fatal(1, "timeout");
    end

endmodule
